lc3_mem_access: RTL and testbench

- Memory-access stage of the LC3 pipeline, directly downstream of the pipeline controller.
- Consumes the controller's `mem_state` request code and the execute-stage address/store data.
- Runs single or two-phase (indirect) transactions on a variable-latency data-memory handshake.
- Returns `complete_data` to the controller and the load result to writeback.

---
 rtl/lc3_pkg.sv | 39 +++
 rtl/lc3_mem_watchdog.sv | 30 +++
 rtl/lc3_mem_access.sv | 129 ++++++++++++
 tb/tb_lc3_mem_access.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared LC3 pipeline types: controller memory request codes, opcodes, mem-stage FSM states.
// Pure declarations; no latency or backpressure of its own.
package lc3_pkg;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    MS_READ  = 2'd0,
    MS_IND   = 2'd1,
    MS_WRITE = 2'd2,
    MS_IDLE  = 2'd3
  } mem_state_t;

  typedef enum logic [3:0] {
    OP_BR   = 4'd0,
    OP_ADD  = 4'd1,
    OP_LD   = 4'd2,
    OP_ST   = 4'd3,
    OP_JSR  = 4'd4,
    OP_AND  = 4'd5,
    OP_LDR  = 4'd6,
    OP_STR  = 4'd7,
    OP_RTI  = 4'd8,
    OP_NOT  = 4'd9,
    OP_LDI  = 4'd10,
    OP_STI  = 4'd11,
    OP_JMP  = 4'd12,
    OP_RES  = 4'd13,
    OP_LEA  = 4'd14,
    OP_TRAP = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mem_fsm_t;

endpackage

// File: rtl/lc3_mem_watchdog.sv
// Cycle counter for an outstanding data-memory request; expired is combinational off the count.
// Flags at TIMEOUT_CYCLES-1 held cycles; no backpressure, clear dominates enable.
module lc3_mem_watchdog
  import lc3_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lc3_mem_access.sv
// LC3 memory-access stage: single or pointer-then-data accesses over a req/ack data-memory port.
// Req-to-complete >= 2 cycles; holds req until ack or watchdog abort, ignores new codes until phase done.
module lc3_mem_access
  import lc3_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_state,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_din,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        complete_data,
  output logic [15:0] memout,
  output logic        mem_err
);

  mem_fsm_t   r_state;
  mem_state_t r_cur;
  mem_state_t r_served;
  logic [15:0] r_ind_ptr;
  logic        r_ind_valid;
  logic        r_req;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_din;
  logic        r_cpl;
  logic [15:0] r_memout;
  logic        r_err;

  mem_state_t w_ms;
  logic       w_in_req;
  logic       w_expired;
  logic       w_use_ptr;

  assign w_ms      = mem_state_t'(mem_state);
  assign w_in_req  = (r_state == ST_REQ);
  assign w_use_ptr = r_ind_valid && ((w_ms == MS_READ) || (w_ms == MS_WRITE));

  lc3_mem_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (!w_in_req),
    .i_en      (w_in_req && !dmem_ack),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cur       <= MS_IDLE;
      r_served    <= MS_IDLE;
      r_ind_ptr   <= '0;
      r_ind_valid <= 1'b0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_cpl       <= 1'b0;
      r_memout    <= '0;
      r_err       <= 1'b0;
    end else begin
      r_cpl <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // The controller holds its code while it sees complete_data; served blocks a replay.
          if (w_ms == MS_IDLE) begin
            r_served    <= MS_IDLE;
            r_ind_valid <= 1'b0;
          end else if (w_ms != r_served) begin
            r_state <= ST_REQ;
            r_req   <= 1'b1;
            r_we    <= (w_ms == MS_WRITE);
            r_addr  <= w_use_ptr ? r_ind_ptr : M_Addr;
            r_din   <= M_Data;
            r_cur   <= w_ms;
          end
        end
        ST_REQ: begin
          if (dmem_ack) begin
            r_state  <= ST_DONE;
            r_req    <= 1'b0;
            r_cpl    <= 1'b1;
            r_served <= r_cur;
            case (r_cur)
              MS_READ: begin
                r_memout    <= dmem_rdata;
                r_ind_valid <= 1'b0;
              end
              MS_IND: begin
                r_ind_ptr   <= dmem_rdata;
                r_ind_valid <= 1'b1;
              end
              default: r_ind_valid <= 1'b0;
            endcase
          end else if (w_expired) begin
            r_state     <= ST_DONE;
            r_req       <= 1'b0;
            r_cpl       <= 1'b1;
            r_served    <= r_cur;
            r_err       <= 1'b1;
            r_ind_valid <= 1'b0;
            if (r_cur == MS_READ) r_memout <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_req      = r_req;
  assign dmem_we       = r_we;
  assign dmem_addr     = r_addr;
  assign dmem_din      = r_din;
  assign complete_data = r_cpl;
  assign memout        = r_memout;
  assign mem_err       = r_err;

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed bench for lc3_mem_access with a 4-cycle watchdog: LD, LDI, STI, guard, timeout, reset.
module tb_lc3_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mem_state = 2'd3;
  logic [15:0] M_Addr = '0;
  logic [15:0] M_Data = '0;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_din;
  logic        complete_data;
  logic [15:0] memout;
  logic        mem_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lc3_mem_access #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_state     (mem_state),
    .M_Addr        (M_Addr),
    .M_Data        (M_Data),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_din      (dmem_din),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .complete_data (complete_data),
    .memout        (memout),
    .mem_err       (mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory responder: waits (bounded) for a request, acks `delay` cycles after it is first visible.
  task automatic serve(input int delay, input logic [15:0] rd,
                       output logic got, output logic [15:0] a, output logic we,
                       output logic [15:0] din, output logic stable, output logic cpl);
    got = 1'b0; a = 'x; we = 1'bx; din = 'x; stable = 1'b0; cpl = 1'b0;
    for (int i = 0; i < 20 && dmem_req !== 1'b1; i++) tick();
    if (dmem_req !== 1'b1) return;
    got = 1'b1; a = dmem_addr; we = dmem_we; din = dmem_din; stable = 1'b1;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (dmem_req !== 1'b1 || dmem_addr !== a || dmem_we !== we || dmem_din !== din) stable = 1'b0;
    end
    dmem_ack = 1'b1;
    dmem_rdata = rd;
    tick();
    dmem_ack = 1'b0;
    dmem_rdata = 16'hDEAD;
    cpl = complete_data;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_state = 2'd3;
    tick(); tick();
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
    vectors++; if (dmem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%b exp=0", dmem_we); end
    vectors++; if (dmem_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_addr got=%h exp=0000", dmem_addr); end
    vectors++; if (dmem_din !== 16'h0000) begin miscompares++; $display("FAIL rst_din got=%h exp=0000", dmem_din); end
    vectors++; if (complete_data !== 1'b0) begin miscompares++; $display("FAIL rst_cpl got=%b exp=0", complete_data); end
    vectors++; if (memout !== 16'h0000) begin miscompares++; $display("FAIL rst_memout got=%h exp=0000", memout); end
    vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b exp=0", mem_err); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_ld();
    logic got, we, stable, cpl;
    logic [15:0] a, din;
    M_Addr = 16'h3000; M_Data = 16'h1111; mem_state = 2'd0;
    serve(3, 16'hBEEF, got, a, we, din, stable, cpl);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL ld_req got=%b exp=1", got); end
    vectors++; if (a !== 16'h3000) begin miscompares++; $display("FAIL ld_addr got=%h exp=3000", a); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL ld_we got=%b exp=0", we); end
    vectors++; if (stable !== 1'b1) begin miscompares++; $display("FAIL ld_stable got=%b exp=1", stable); end
    vectors++; if (cpl !== 1'b1) begin miscompares++; $display("FAIL ld_cpl got=%b exp=1", cpl); end
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL ld_req_drop got=%b exp=0", dmem_req); end
    vectors++; if (memout !== 16'hBEEF) begin miscompares++; $display("FAIL ld_memout got=%h exp=beef", memout); end
    vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL ld_err got=%b exp=0", mem_err); end
    tick();
    vectors++; if (complete_data !== 1'b0) begin miscompares++; $display("FAIL ld_cpl_pulse got=%b exp=0", complete_data); end
    mem_state = 2'd3;
    tick(); tick();
  endtask

  task automatic test_ldi();
    logic got, we, stable, cpl;
    logic [15:0] a, din;
    M_Addr = 16'h3010; mem_state = 2'd1;
    serve(0, 16'h4000, got, a, we, din, stable, cpl);
    vectors++; if (a !== 16'h3010) begin miscompares++; $display("FAIL ldi_ptr_addr got=%h exp=3010", a); end
    vectors++; if (cpl !== 1'b1) begin miscompares++; $display("FAIL ldi_cpl1 got=%b exp=1", cpl); end
    vectors++; if (memout !== 16'hBEEF) begin miscompares++; $display("FAIL ldi_memout_hold got=%h exp=beef", memout); end
    mem_state = 2'd0; M_Addr = 16'h9999;
    serve(1, 16'h1234, got, a, we, din, stable, cpl);
    vectors++; if (a !== 16'h4000) begin miscompares++; $display("FAIL ldi_data_addr got=%h exp=4000", a); end
    vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL ldi_we got=%b exp=0", we); end
    vectors++; if (cpl !== 1'b1) begin miscompares++; $display("FAIL ldi_cpl2 got=%b exp=1", cpl); end
    vectors++; if (memout !== 16'h1234) begin miscompares++; $display("FAIL ldi_memout got=%h exp=1234", memout); end
    mem_state = 2'd3;
    tick(); tick();
  endtask

  task automatic test_sti();
    logic got, we, stable, cpl;
    logic [15:0] a, din;
    M_Addr = 16'h3020; M_Data = 16'hA5A5; mem_state = 2'd1;
    serve(2, 16'h5000, got, a, we, din, stable, cpl);
    vectors++; if (a !== 16'h3020) begin miscompares++; $display("FAIL sti_ptr_addr got=%h exp=3020", a); end
    mem_state = 2'd2;
    serve(0, 16'h0BAD, got, a, we, din, stable, cpl);
    vectors++; if (a !== 16'h5000) begin miscompares++; $display("FAIL sti_wr_addr got=%h exp=5000", a); end
    vectors++; if (we !== 1'b1) begin miscompares++; $display("FAIL sti_we got=%b exp=1", we); end
    vectors++; if (din !== 16'hA5A5) begin miscompares++; $display("FAIL sti_din got=%h exp=a5a5", din); end
    vectors++; if (cpl !== 1'b1) begin miscompares++; $display("FAIL sti_cpl got=%b exp=1", cpl); end
    vectors++; if (memout !== 16'h1234) begin miscompares++; $display("FAIL sti_memout got=%h exp=1234", memout); end
    mem_state = 2'd3;
    tick(); tick();
  endtask

  task automatic test_guard();
    logic got, we, stable, cpl;
    logic [15:0] a, din;
    int n_req, n_cpl;
    M_Addr = 16'h3100; mem_state = 2'd0;
    serve(0, 16'h0042, got, a, we, din, stable, cpl);
    vectors++; if (memout !== 16'h0042) begin miscompares++; $display("FAIL guard_memout1 got=%h exp=0042", memout); end
    n_req = 0; n_cpl = 0;
    dmem_ack = 1'b1; dmem_rdata = 16'hFFFF;
    repeat (5) begin
      tick();
      if (dmem_req !== 1'b0) n_req++;
      if (complete_data !== 1'b0) n_cpl++;
    end
    dmem_ack = 1'b0;
    vectors++; if (n_req !== 0) begin miscompares++; $display("FAIL guard_no_req got=%0d exp=0", n_req); end
    vectors++; if (n_cpl !== 0) begin miscompares++; $display("FAIL guard_no_cpl got=%0d exp=0", n_cpl); end
    vectors++; if (memout !== 16'h0042) begin miscompares++; $display("FAIL guard_stray_ack got=%h exp=0042", memout); end
    mem_state = 2'd3;
    tick();
    mem_state = 2'd0;
    serve(1, 16'h0077, got, a, we, din, stable, cpl);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL guard_relaunch got=%b exp=1", got); end
    vectors++; if (a !== 16'h3100) begin miscompares++; $display("FAIL guard_addr got=%h exp=3100", a); end
    vectors++; if (memout !== 16'h0077) begin miscompares++; $display("FAIL guard_memout2 got=%h exp=0077", memout); end
    mem_state = 2'd3;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    M_Addr = 16'h3200; mem_state = 2'd0;
    tick();
    n = 0;
    while (dmem_req === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    vectors++; if (n !== 4) begin miscompares++; $display("FAIL to_req_cycles got=%0d exp=4", n); end
    vectors++; if (complete_data !== 1'b1) begin miscompares++; $display("FAIL to_cpl got=%b exp=1", complete_data); end
    vectors++; if (mem_err !== 1'b1) begin miscompares++; $display("FAIL to_err got=%b exp=1", mem_err); end
    vectors++; if (memout !== 16'h0000) begin miscompares++; $display("FAIL to_memout got=%h exp=0000", memout); end
    mem_state = 2'd3;
    repeat (5) tick();
    vectors++; if (mem_err !== 1'b1) begin miscompares++; $display("FAIL to_err_sticky got=%b exp=1", mem_err); end
  endtask

  task automatic test_reset_mid();
    logic got, we, stable, cpl;
    logic [15:0] a, din;
    M_Addr = 16'h3300; M_Data = 16'h7777; mem_state = 2'd1;
    serve(0, 16'h6000, got, a, we, din, stable, cpl);
    mem_state = 2'd0;
    tick(); tick();
    vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL rm_req_up got=%b exp=1", dmem_req); end
    vectors++; if (dmem_addr !== 16'h6000) begin miscompares++; $display("FAIL rm_ptr_addr got=%h exp=6000", dmem_addr); end
    rst = 1'b0;
    tick();
    vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL rm_req got=%b exp=0", dmem_req); end
    vectors++; if (complete_data !== 1'b0) begin miscompares++; $display("FAIL rm_cpl got=%b exp=0", complete_data); end
    vectors++; if (dmem_addr !== 16'h0000) begin miscompares++; $display("FAIL rm_addr got=%h exp=0000", dmem_addr); end
    vectors++; if (dmem_din !== 16'h0000) begin miscompares++; $display("FAIL rm_din got=%h exp=0000", dmem_din); end
    vectors++; if (memout !== 16'h0000) begin miscompares++; $display("FAIL rm_memout got=%h exp=0000", memout); end
    vectors++; if (mem_err !== 1'b0) begin miscompares++; $display("FAIL rm_err got=%b exp=0", mem_err); end
    rst = 1'b1;
    serve(0, 16'h0ABC, got, a, we, din, stable, cpl);
    vectors++; if (a !== 16'h3300) begin miscompares++; $display("FAIL rm_ind_cleared got=%h exp=3300", a); end
    vectors++; if (memout !== 16'h0ABC) begin miscompares++; $display("FAIL rm_memout2 got=%h exp=0abc", memout); end
    mem_state = 2'd3;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_ld();
    test_ldi();
    test_sti();
    test_guard();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=hung exp=finished");
    $fatal(1);
  end

endmodule
